// File: rtl/rr_arb2_mux_feeder_pkg.sv
// Shared definitions for the two-channel round-robin mux feeder.
// Purpose : state encodings, default burst parameters and small helpers
//           reused by the arbiter core, the top level, and neighbouring
//           requester/consumer blocks.
// Contents: arbState_e (ST_IDLE/ST_G0/ST_G1), DEFAULT_MAX_BURST,
//           DEFAULT_CNT_W, chState(), gntDecode().
package rr_arb2_mux_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arbState_e;

  localparam int DEFAULT_MAX_BURST = 4;
  localparam int DEFAULT_CNT_W     = 4;

  // Maps a channel number onto the grant state that serves it.
  function automatic arbState_e chState(input logic ch);
    return ch ? ST_G1 : ST_G0;
  endfunction

  // One-hot grant vector for a state; idle (and any unused code) grants nobody.
  function automatic logic [1:0] gntDecode(input arbState_e st);
    logic [1:0] g;
    g = 2'b00;
    if (st == ST_G0) g = 2'b01;
    if (st == ST_G1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/rr_arb2_mux_feeder_core.sv
// Round-robin arbitration core for two requesters with burst limiting.
// Purpose : holds the grant state, the "last served" channel and the beat
//           counter; independent of the data width so it can feed other muxes.
// Ports   : clk_i     rising-edge clock
//           rst_i     synchronous active-high reset
//           req_i     per-channel request
//           gnt_o     one-hot grant decoded from the state register
//           beat_o    a beat happens this cycle (granted channel requesting)
//           beatCh_o  channel owning the current grant (valid with beat_o)
module rr_arb2_mux_feeder_core
  import rr_arb2_mux_feeder_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       beat_o,
  output logic       beatCh_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arbState_e        state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic curCh;
  logic ownReq;
  logic otherReq;

  // State, last-served channel and burst counter registers.
  // last resets to 1 so channel 0 wins the very first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A granted channel keeps the grant while it requests;
  // at the burst limit it yields only if the other side is waiting, otherwise
  // the counter simply wraps and the grant continues.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    curCh    = (state_q == ST_G1);
    ownReq   = req_i[curCh];
    otherReq = req_i[!curCh];

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_i == 2'b11)  state_d = chState(!last_q);
        else if (req_i[0])   state_d = ST_G0;
        else if (req_i[1])   state_d = ST_G1;
      end
      ST_G0, ST_G1: begin
        if (!ownReq) begin
          cnt_d   = '0;
          state_d = otherReq ? chState(!curCh) : ST_IDLE;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (otherReq) state_d = chState(!curCh);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Remember who was granted on every fresh entry into a grant state.
    if (state_d != state_q && state_d != ST_IDLE) begin
      last_d = (state_d == ST_G1);
    end
  end

  assign gnt_o    = gntDecode(state_q);
  assign beat_o   = ownReq && (state_q != ST_IDLE);
  assign beatCh_o = curCh;

endmodule

// File: rtl/rr_arb2_mux_feeder.sv
// Two-channel round-robin arbiter feeding a 2:1 single-bit vector mux.
// Purpose : grants one requester at a time (burst limited), registers each
//           granted beat and presents an aligned select/data/valid triple
//           one cycle after the beat.
// Ports   : clk      rising-edge clock
//           rst      synchronous active-high reset
//           req[1:0] per-channel request
//           din[1:0] per-channel data bit, used only on that channel's beat
//           gnt[1:0] one-hot grant, 00 when idle
//           s        mux select (1 = channel 1)
//           a[1:0]   mux data; beat bit at a[s], the other bit 0
//           y_valid  a/s carry a valid beat
module rr_arb2_mux_feeder
  import rr_arb2_mux_feeder_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] din,
  output logic [1:0] gnt,
  output logic       s,
  output logic [1:0] a,
  output logic       y_valid
);

  logic       beat;
  logic       beatCh;

  logic       yValid_q, yValid_d;
  logic       s_q, s_d;
  logic [1:0] a_q, a_d;

  rr_arb2_mux_feeder_core #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) uCore (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .beat_o   (beat),
    .beatCh_o (beatCh)
  );

  // Beat capture. Only the granted channel's din bit is ever selected, so an
  // unknown value on the idle channel cannot leak into a. Without a beat the
  // select/data hold and only valid drops.
  always_comb begin
    yValid_d = 1'b0;
    s_d      = s_q;
    a_d      = a_q;
    if (beat) begin
      yValid_d = 1'b1;
      s_d      = beatCh;
      a_d      = beatCh ? {din[1], 1'b0} : {1'b0, din[0]};
    end
  end

  // Output registers; reset drops any in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      yValid_q <= 1'b0;
      s_q      <= 1'b0;
      a_q      <= 2'b00;
    end else begin
      yValid_q <= yValid_d;
      s_q      <= s_d;
      a_q      <= a_d;
    end
  end

  assign y_valid = yValid_q;
  assign s       = s_q;
  assign a       = a_q;

endmodule
